// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory that answers one cache
// request at a time. After a fixed LATENCY it gives a one-cycle mem_ready
// pulse, with read data on mem_data. The FSM steps IDLE -> WAIT -> RESP -> IDLE.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cache_op,
    input  logic        cache_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] cache_write_data,
    output logic        mem_ready,
    output logic [31:0] mem_data,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [3:0]          w_next_cnt;

    // Request captured at acceptance; inputs are ignored once a request is in flight.
    logic                r_op;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;

    logic [31:0]         r_mem_data;

    // NOTE: the memory array is never reset; reset only aborts a transaction.
    // The declaration initialiser gives all-zero contents at time 0 in simulation.
    logic [31:0]         r_mem [DEPTH] = '{default: 32'h0};

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_sel_op;
    logic [ADDR_W-1:0]   w_in_idx;
    logic [ADDR_W-1:0]   w_sel_idx;
    logic [31:0]         w_sel_wdata;

    // The byte-offset bits and the bits above the word index alias away on purpose.
    logic                w_unused_addr;
    assign w_unused_addr = ^{mem_addr[1:0], mem_addr[31:ADDR_W+2]};

    assign w_in_idx = mem_addr[ADDR_W+1:2];
    assign w_accept = (r_state == S_IDLE) && cache_valid;

    // With LATENCY=1, RESP is entered on the acceptance edge itself.
    // On that edge the live inputs are used, because the latched copy is not loaded yet.
    assign w_sel_op    = w_accept ? cache_op         : r_op;
    assign w_sel_idx   = w_accept ? w_in_idx         : r_idx;
    assign w_sel_wdata = w_accept ? cache_write_data : r_wdata;

    // RESP is never followed by RESP, so any edge leading into RESP is an entry edge.
    assign w_enter_resp = (w_next_state == S_RESP);

    assign mem_ready = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign mem_data  = r_mem_data;

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (cache_valid) begin
                    w_next_cnt   = 4'(LATENCY - 1);
                    w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // State, counter and request capture registers.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (!nrst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_op    <= cache_op;
                r_idx   <= w_in_idx;
                r_wdata <= cache_write_data;
            end
        end
    end

    // Read data register: loaded on the edge that enters RESP for a read, held otherwise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mem_data <= 32'h0;
        end else if (w_enter_resp && w_sel_op) begin
            r_mem_data <= r_mem[w_sel_idx];
        end
    end

    // Memory write on the edge that enters RESP for a write.
    always_ff @(posedge clk) begin
        if (w_enter_resp && !w_sel_op) begin
            r_mem[w_sel_idx] <= w_sel_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// It drives a LATENCY=3 instance through a vector table and several
// hand-written sequences: back-to-back, reset abort and input churn.
// A second instance built with LATENCY=1 covers the single-cycle case.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        nrst;

    logic        cache_op, cache_valid;
    logic [31:0] mem_addr, cache_write_data;
    logic        mem_ready, busy;
    logic [31:0] mem_data;

    logic        l1_op, l1_valid;
    logic [31:0] l1_addr, l1_wdata;
    logic        l1_ready, l1_busy;
    logic [31:0] l1_data;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_rd  = 32'h0;
    logic [31:0] last_rd1 = 32'h0;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .LATENCY(3)) u_dut (
        .clk              (clk),
        .nrst             (nrst),
        .cache_op         (cache_op),
        .cache_valid      (cache_valid),
        .mem_addr         (mem_addr),
        .cache_write_data (cache_write_data),
        .mem_ready        (mem_ready),
        .mem_data         (mem_data),
        .busy             (busy)
    );

    data_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
        .clk              (clk),
        .nrst             (nrst),
        .cache_op         (l1_op),
        .cache_valid      (l1_valid),
        .mem_addr         (l1_addr),
        .cache_write_data (l1_wdata),
        .mem_ready        (l1_ready),
        .mem_data         (l1_data),
        .busy             (l1_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input bit s, input logic v, input logic op,
                         input logic [31:0] a, input logic [31:0] wd);
        if (s) begin
            l1_valid = v; l1_op = op; l1_addr = a; l1_wdata = wd;
        end else begin
            cache_valid = v; cache_op = op; mem_addr = a; cache_write_data = wd;
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? l1_ready : mem_ready;
    endfunction

    function automatic logic bsy(input bit s);
        return s ? l1_busy : busy;
    endfunction

    function automatic logic [31:0] md(input bit s);
        return s ? l1_data : mem_data;
    endfunction

    // One transaction. It is called at a negedge with the DUT idle and returns
    // at the negedge after the response, again idle. The inputs are scrambled,
    // and valid is dropped, right after acceptance.
    task automatic txn(input bit s, input string tag, input logic op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat);
        int          lat;
        logic [31:0] exp_md;
        drive(s, 1'b1, op, addr, wd);
        @(posedge clk);
        @(negedge clk);
        drive(s, 1'b0, ~op, ~addr, ~wd);
        check({tag, " busy"}, 32'(bsy(s)), 32'd1);
        lat = 1;
        while (!rdy(s) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        exp_md = op ? exp_rd : (s ? last_rd1 : last_rd);
        check({tag, " data"}, md(s), exp_md);
        if (op) begin
            if (s) last_rd1 = exp_rd;
            else   last_rd  = exp_rd;
        end
        @(negedge clk);
        check({tag, " pulse width"}, 32'(rdy(s)), 32'd0);
        check({tag, " idle after"}, 32'(bsy(s)), 32'd0);
    endtask

    initial begin
        int lat;

        // op, byte address, write data, expected read data (ADDR_W=10)
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h1111_0000, 32'h0};          // write word 4
        vecs[1] = '{1'b1, 32'h0000_0010, 32'h0,         32'h1111_0000};  // read it back
        vecs[2] = '{1'b0, 32'h0000_1000, 32'h5555_5555, 32'h0};          // aliases word 0
        vecs[3] = '{1'b1, 32'h0000_0000, 32'h0,         32'h5555_5555};
        vecs[4] = '{1'b1, 32'h0000_0003, 32'h0,         32'h5555_5555};  // low bits ignored
        vecs[5] = '{1'b0, 32'h0000_0FFC, 32'hA5A5_0001, 32'h0};          // top word 1023
        vecs[6] = '{1'b1, 32'h0000_7FFC, 32'h0,         32'hA5A5_0001};  // aliases word 1023
        vecs[7] = '{1'b1, 32'h0000_0020, 32'h0,         32'h0};          // untouched word

        nrst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset ready", 32'(mem_ready), 32'd0);
        check("reset data", mem_data, 32'h0);
        check("reset l1 busy", 32'(l1_busy), 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            txn(1'b0, $sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 3);
        end

        // Back-to-back with valid held: write, then switch to read in the idle cycle.
        // 0x2020 and 0x1020 both map to word 8 when ADDR_W=10.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_1020, 32'h1010_1010);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_ready && lat < 20);
        check("b2b write latency", 32'(lat), 32'd3);
        @(negedge clk);
        check("b2b idle cycle", 32'(busy), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_2020, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("b2b second accept", 32'(busy), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!mem_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b read latency", 32'(lat), 32'd3);
        check("b2b read data", mem_data, 32'h1010_1010);
        last_rd = 32'h1010_1010;
        @(negedge clk);
        check("b2b pulse width", 32'(mem_ready), 32'd0);
        txn(1'b0, "b2b verify", 1'b1, 32'h0000_1020, 32'h0, 32'h1010_1010, 3);

        // Input churn: txn scrambles address/op and drops valid during WAIT.
        txn(1'b0, "churn rd0", 1'b1, 32'h0000_0000, 32'h0, 32'h5555_5555, 3);
        txn(1'b0, "churn rd4", 1'b1, 32'h0000_0004, 32'h0, 32'h0, 3);

        // Reset one cycle after accepting a write: the write must not land.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("abort busy before", 32'(busy), 32'd1);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort ready", 32'(mem_ready), 32'd0);
        check("abort data cleared", mem_data, 32'h0);
        last_rd = 32'h0;
        repeat (2) begin
            @(negedge clk);
            check("abort ready held", 32'(mem_ready), 32'd0);
        end
        nrst = 1'b1;
        txn(1'b0, "abort verify", 1'b1, 32'h0000_0008, 32'h0, 32'h0, 3);

        // LATENCY=1 instance.
        txn(1'b1, "l1 wr", 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1);
        txn(1'b1, "l1 rd", 1'b1, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1);
        txn(1'b1, "l1 alias", 1'b1, 32'h0000_1040, 32'h0, 32'hCAFE_F00D, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
